// File: rtl/dht11_pkg.sv
// dht11_pkg
// Definitions shared by the DHT11 responder and the host-side DHT11 reader:
// the protocol state enum, frame geometry, the collision blanking window and
// the frame checksum.
`timescale 1ns/1ps
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOST_LOW,
    RESP_WAIT,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } dht11_state_e;

  localparam int FRAME_BITS = 40;
  // Released phases ignore a low line for this many us after entry, which
  // covers the synchronizer delay and the pull-up rise time.
  localparam int BLANK_US = 3;

  // Checksum is the 8-bit wrapping sum of the four data bytes; the two
  // decimal bytes are always zero here.
  function automatic logic [7:0] dht11_chk(input logic [7:0] hum,
                                           input logic [7:0] temp);
    return hum + temp;
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick
// One-clock strobe every microsecond, derived from CLK_HZ by a reloading
// down-counter. clr_i restarts the count so a new phase begins on a whole
// microsecond boundary.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   clr_i    in  restart the microsecond period
//   tick_o   out one-cycle strobe at the end of each microsecond
`timescale 1ns/1ps
module dht11_us_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int DIV = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - W'(1);
    if (clr_i || cnt_q == '0) cnt_d = RELOAD;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= RELOAD;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dht11_responder.sv
// dht11_responder
// Emulates a DHT11 sensor on an open-drain single-wire line: measures the
// host start pulse and answers with the 40-bit frame
// {humidity, 8'h00, temperature, 8'h00, checksum}, MSB first.
// Optional build macro: DHT11_ERR_INJECT_EN adds corrupt_chk, which flips
// checksum bit 0 for the frame it is snapshotted with.
// Ports:
//   clk          in    system clock
//   reset_n      in    asynchronous active-low reset
//   dht11_data   inout open-drain line, driven 0 or Z only
//   humidity     in    integer %RH to report
//   temperature  in    integer degC to report
//   busy         out   start accepted until frame released
//   frame_done   out   pulse after end-of-frame release
//   bad_start    out   pulse on a host low shorter than START_MIN_US
//   collision    out   pulse on a low seen while the line is released
//   corrupt_chk  in    (DHT11_ERR_INJECT_EN only) invert checksum bit 0
//
// state     | meaning
// IDLE      | line released, waiting for host falling edge
// HOST_LOW  | timing host low pulse
// RESP_WAIT | released, delay before response
// RESP_LOW  | driving response low
// RESP_HIGH | released, response high
// BIT_LOW   | driving bit preamble low
// BIT_HIGH  | released, width encodes current bit
// END_LOW   | driving end-of-frame low
`timescale 1ns/1ps
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int RESP_LOW_US   = 80,
  parameter int RESP_HIGH_US  = 80,
  parameter int BIT_LOW_US    = 50,
  parameter int BIT0_HIGH_US  = 26,
  parameter int BIT1_HIGH_US  = 70
) (
  input  logic       clk,
  input  logic       reset_n,
  inout  wire        dht11_data,
  input  logic [7:0] humidity,
  input  logic [7:0] temperature,
  output logic       busy,
  output logic       frame_done,
  output logic       bad_start,
  output logic       collision
`ifdef DHT11_ERR_INJECT_EN
  ,
  input  logic       corrupt_chk
`endif
);

  dht11_state_e state_q, state_d;
  logic [15:0]  us_q, us_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [5:0]   bit_q, bit_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         bad_q, bad_d;
  logic         coll_q, coll_d;
  logic [1:0]   sync_q;
  logic         prev_q;

  logic        tick, phase_chg, phase_end, line_s, fall, rise, drive_low, low_late;
  logic [15:0] phase_len;
  logic [7:0]  chk;

  dht11_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (phase_chg),
    .tick_o (tick)
  );

  // Driven only in the low phases; state resets asynchronously, so reset
  // releases the line without waiting for a clock.
  assign drive_low  = (state_q == RESP_LOW) || (state_q == BIT_LOW) || (state_q == END_LOW);
  assign dht11_data = drive_low ? 1'b0 : 1'bz;

  assign line_s   = sync_q[1];
  assign fall     = prev_q & ~line_s;
  assign rise     = ~prev_q & line_s;
  assign low_late = ~line_s && (us_q >= 16'(BLANK_US));

`ifdef DHT11_ERR_INJECT_EN
  assign chk = dht11_chk(humidity, temperature) ^ {7'd0, corrupt_chk};
`else
  assign chk = dht11_chk(humidity, temperature);
`endif

  always_comb begin
    phase_len = 16'd0;
    case (state_q)
      RESP_WAIT:         phase_len = 16'(RESP_DELAY_US);
      RESP_LOW:          phase_len = 16'(RESP_LOW_US);
      RESP_HIGH:         phase_len = 16'(RESP_HIGH_US);
      BIT_LOW, END_LOW:  phase_len = 16'(BIT_LOW_US);
      BIT_HIGH:          phase_len = sh_q[FRAME_BITS-1] ? 16'(BIT1_HIGH_US) : 16'(BIT0_HIGH_US);
      default:           phase_len = 16'd0;
    endcase
  end

  // Phase of N us ends on the Nth tick since entry.
  assign phase_end = tick && (us_q == phase_len - 16'd1);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bad_d   = 1'b0;
    coll_d  = 1'b0;
    case (state_q)
      IDLE:
        if (fall) state_d = HOST_LOW;
      HOST_LOW:
        if (rise) begin
          if (us_q >= 16'(START_MIN_US)) begin
            sh_d    = {humidity, 8'h00, temperature, 8'h00, chk};
            busy_d  = 1'b1;
            state_d = RESP_WAIT;
          end else begin
            bad_d   = 1'b1;
            state_d = IDLE;
          end
        end
      RESP_WAIT:
        if (fall) begin
          coll_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (phase_end) begin
          state_d = RESP_LOW;
        end
      RESP_LOW:
        if (phase_end) state_d = RESP_HIGH;
      RESP_HIGH:
        if (low_late) begin
          coll_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (phase_end) begin
          bit_d   = 6'd0;
          state_d = BIT_LOW;
        end
      BIT_LOW:
        if (phase_end) state_d = BIT_HIGH;
      BIT_HIGH:
        if (low_late) begin
          coll_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (phase_end) begin
          sh_d    = {sh_q[FRAME_BITS-2:0], 1'b0};
          bit_d   = bit_q + 6'd1;
          state_d = (bit_q == 6'(FRAME_BITS - 1)) ? END_LOW : BIT_LOW;
        end
      END_LOW:
        if (phase_end) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end

  // Every transition restarts both the us counter and the tick divider.
  assign phase_chg = (state_d != state_q);

  always_comb begin
    us_d = us_q;
    if (phase_chg)                  us_d = 16'd0;
    else if (tick && us_q != '1)    us_d = us_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      us_q    <= 16'd0;
      sh_q    <= '0;
      bit_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
      coll_q  <= 1'b0;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      us_q    <= us_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bad_q   <= bad_d;
      coll_q  <= coll_d;
      sync_q  <= {sync_q[0], dht11_data};
      prev_q  <= line_s;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign bad_start  = bad_q;
  assign collision  = coll_q;

endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
- Emulates a DHT11 humidity/temperature sensor on the single-wire dht11_data line; it is the responder end of the host-side DHT11 reader.
- Used for bench loop-back and for demos without a physical sensor. Host-driven readings come from slide switches or a register.
- Detects the host start pulse, then replies with the standard 40-bit frame: humidity int, humidity dec (0), temperature int, temperature dec (0), checksum.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; a 1 µs tick is derived from it.
- START_MIN_US, 18000, minimum host low time accepted as a start request.
- RESP_DELAY_US, 30, wait after host release before the response begins.
- RESP_LOW_US, 80, response low phase.
- RESP_HIGH_US, 80, response high phase.
- BIT_LOW_US, 50, low preamble before each bit and end-of-frame low.
- BIT0_HIGH_US, 26, high time for a '0' bit.
- BIT1_HIGH_US, 70, high time for a '1' bit.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- dht11_data  inout  1  open-drain line; driven 0 or Z only, never 1 (external pull-up)
- humidity  input  8  humidity value to report (integer %RH)
- temperature  input  8  temperature value to report (integer °C)
- busy  output  1  high from start detection until the line is released after the frame
- frame_done  output  1  one-cycle pulse after end-of-frame release
- bad_start  output  1  one-cycle pulse when a host low is shorter than START_MIN_US
- collision  output  1  one-cycle pulse when the line is seen low during a released phase

Behaviour:
- Reset: the line is released (Z) immediately, asynchronously. busy=0, frame_done=0, bad_start=0, collision=0. State goes to IDLE and all counters clear.
- Line sampling goes through a 2-flop synchronizer. All timing uses a 1 µs tick with a µs counter; phase lengths are exact to ±1 µs.
- FSM states: IDLE, HOST_LOW, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
- IDLE → HOST_LOW on a synchronized falling edge. The µs counter starts.
- HOST_LOW, on a rising edge:
  - If count ≥ START_MIN_US: snapshot humidity and temperature into a 40-bit shift register {hum, 8'h00, temp, 8'h00, chk}, where chk = (hum + temp) mod 256 (8-bit wrap). Assert busy, then go to RESP_WAIT.
  - Otherwise pulse bad_start and return to IDLE.
  - The low counter saturates; it does not wrap.
- RESP_WAIT (released) for RESP_DELAY_US → RESP_LOW (drive 0) → RESP_HIGH (released) → BIT_LOW.
- BIT_LOW drives 0 for BIT_LOW_US → BIT_HIGH, released for BIT0_HIGH_US or BIT1_HIGH_US per the shift register MSB. Bits are sent MSB first, humidity byte first.
- After bit 40: END_LOW drives 0 for BIT_LOW_US, then releases, pulses frame_done, clears busy, and returns to IDLE.
- Collision check: in RESP_HIGH or BIT_HIGH, a synchronized low seen after the first 3 µs of the phase pulses collision and aborts to IDLE with the line released. This blanking window covers synchronizer and pull-up latency.
- A host falling edge during RESP_WAIT is treated as a collision.
- Input changes during a frame do not affect it; the snapshot only is used.
- The IDLE re-arm is immediate; a new start may begin the cycle after frame_done.

Optional Feature:
- Macro DHT11_ERR_INJECT_EN.
- When defined, adds input port corrupt_chk (1 bit). It is sampled with the snapshot; when 1, bit 0 of the checksum is inverted for that frame.
- When undefined, the port is absent and the checksum is always correct.

Decomposition:
- Shared package dht11_pkg holds:
  - the state enum;
  - frame width constant FRAME_BITS=40;
  - the collision blanking constant BLANK_US=3;
  - the checksum function (8-bit wrapping sum).
  The host-side reader reuses the same package.
- One sub-module, dht11_us_tick: CLK_HZ-parameterized 1 µs strobe generator, using reset_n.

Test Plan:
- Run benches with START_MIN_US overridden to 180 for speed.
- hum=55, temp=24; host low 200 µs then release → after 30 µs: 80 µs low, 80 µs high, then frame 0x37 0x00 0x18 0x00 0x4F decoded by high width (26 µs = 0, 70 µs = 1); frame_done pulses once; busy high throughout.
- hum=200, temp=100 → checksum byte 0x2C (300 mod 256).
- Host low 100 µs → bad_start pulse, line never driven, busy stays 0.
- hum=55, temp=24; change humidity to 99 during bit 10 → transmitted humidity byte still 0x37.
- Bench pulls the line low 10 µs into bit 5's high phase → collision pulse, line released, busy=0, next valid start produces a full frame.
- Assert reset_n low during RESP_LOW → line is Z in the same cycle, all outputs 0; after release a new start is answered normally.
- With DHT11_ERR_INJECT_EN and corrupt_chk=1 → checksum 0x4E for hum=55, temp=24.
